// File: rtl/data_cache.sv
// Direct-mapped, write-through, read-allocate data cache with 4-word lines.
// Optional feature: define DCACHE_STATS_EN to add the o_hit_cnt/o_miss_cnt ports.
module data_cache #(
  parameter int INDEX_BITS = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        i_en,
  input  logic        i_rw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_miss_cnt
`endif
);

  localparam int TAG_BITS = 28 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

  state_e              state_q;
  logic [1:0]          beat_q;
  logic [LINES-1:0]    valid_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [31:0]         mem_addr_q;
  logic [31:0]         mem_wdata_q;

  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES][4];

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [1:0]            req_off;
  logic                  req_hit;
  logic                  rd_hit;
  logic                  rd_miss;
  logic                  wr_req;

  assign req_tag = i_addr[31:4+INDEX_BITS];
  assign req_idx = i_addr[3+INDEX_BITS:4];
  assign req_off = i_addr[3:2];
  assign req_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign rd_hit  = (state_q == IDLE) && i_en && !i_rw && req_hit;
  assign rd_miss = (state_q == IDLE) && i_en && !i_rw && !req_hit;
  assign wr_req  = (state_q == IDLE) && i_en && i_rw;

  // During FILL/WRITE the latched memory address doubles as the held request.
  logic [TAG_BITS-1:0]   lat_tag;
  logic [INDEX_BITS-1:0] lat_idx;
  logic                  lat_hit;
  logic                  fill_ack;
  logic                  write_ack;

  assign lat_tag   = mem_addr_q[31:4+INDEX_BITS];
  assign lat_idx   = mem_addr_q[3+INDEX_BITS:4];
  assign lat_hit   = valid_q[lat_idx] && (tag_mem[lat_idx] == lat_tag);
  assign fill_ack  = (state_q == FILL) && mem_ack;
  assign write_ack = (state_q == WRITE) && mem_ack;

  logic unused_addr_bits;
  assign unused_addr_bits = ^i_addr[1:0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_miss) begin
            state_q    <= FILL;
            beat_q     <= '0;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {i_addr[31:4], 4'b0000};
          end else if (wr_req) begin
            state_q     <= WRITE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {i_addr[31:2], 2'b00};
            mem_wdata_q <= i_wdata;
          end
        end
        FILL: begin
          if (mem_ack) begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              state_q          <= IDLE;
              valid_q[lat_idx] <= 1'b1;
              mem_req_q        <= 1'b0;
              mem_addr_q       <= '0;
            end else begin
              mem_addr_q <= mem_addr_q + 32'd4;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state_q     <= DONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays carry no reset; valid_q alone decides whether their contents count.
  always_ff @(posedge Clk) begin
    if (fill_ack) begin
      data_mem[lat_idx][beat_q] <= mem_rdata;
      if (beat_q == 2'd3) tag_mem[lat_idx] <= lat_tag;
    end
    if (write_ack && lat_hit) data_mem[lat_idx][mem_addr_q[3:2]] <= mem_wdata_q;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (rd_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (rd_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`endif

  assign o_rdata   = (!Rst && rd_hit) ? data_mem[req_idx][req_off] : '0;
  assign o_miss    = !Rst && ((state_q == FILL) || (state_q == WRITE) || rd_miss || wr_req);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter INDEX_BITS, default 4, number of index bits; the cache has 2^INDEX_BITS lines.
REQ-002 Parameter TAG_BITS, fixed at 28-INDEX_BITS, is the width of the stored tag (addr[31:4+INDEX_BITS]).
REQ-003 Port Clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port Rst  in  1  reset, asynchronous, active-high.
REQ-005 Port i_en  in  1  access request from the memory-access stage (MA_EN).
REQ-006 Port i_rw  in  1  1 = write, 0 = read (MA_RW).
REQ-007 Port i_addr  in  32  byte address; bits [1:0] ignored.
REQ-008 Port i_wdata  in  32  store data.
REQ-009 Port o_rdata  out  32  load data.
REQ-010 Port o_miss  out  1  stall request to the hazard unit.
REQ-011 Port mem_req  out  1  memory-side request, held until mem_ack.
REQ-012 Port mem_we  out  1  memory-side write strobe.
REQ-013 Port mem_addr  out  32  word-aligned memory address.
REQ-014 Port mem_wdata  out  32  memory write data.
REQ-015 Port mem_ack  in  1  memory beat completed; mem_rdata valid in the same cycle.
REQ-016 Port mem_rdata  in  32  memory read data.

Function
REQ-017 Organisation: direct-mapped, 4 words per line; offset = addr[3:2], index = addr[3+INDEX_BITS:4].
REQ-018 Policy: write-through, no write-allocate, read-allocate.
REQ-019 FSM states are IDLE, FILL, WRITE and DONE.
REQ-020 IDLE read hit: o_rdata is the addressed word combinationally, o_miss=0, and no state change occurs.
REQ-021 IDLE read miss: o_miss=1 combinationally; the block latches tag, index and line base address and goes to FILL.
REQ-022 FILL: mem_req=1, mem_we=0, mem_addr = line base + 4*beat, with beat counting 0..3.
REQ-023 FILL: each mem_ack writes mem_rdata into the line word and increments beat.
REQ-024 FILL: the ack on beat 3 sets the tag and the valid bit and returns the FSM to IDLE; the held request then hits, so o_miss falls.
REQ-025 Read miss latency is the 4 acks plus 1 cycle.
REQ-026 IDLE write (hit or miss): o_miss=1; the block latches address and data and goes to WRITE.
REQ-027 WRITE: mem_req=1, mem_we=1, with the latched address and data.
REQ-028 WRITE, on mem_ack: if the line is valid with a matching tag, the addressed word is updated; the FSM goes to DONE.
REQ-029 DONE: o_miss=0 for exactly one cycle so the pipeline advances, then the FSM returns to IDLE.
REQ-030 o_miss=1 in FILL and WRITE regardless of i_en.
REQ-031 o_miss=0 whenever i_en=0 in IDLE or DONE.
REQ-032 The core holds i_en, i_rw, i_addr and i_wdata stable while o_miss=1; the cache uses only the latched values during FILL and WRITE.
REQ-033 mem_ack is ignored in IDLE and DONE.
REQ-034 mem_req is never deasserted before its ack.
REQ-035 mem_addr, mem_wdata and mem_we are 0 in IDLE and DONE.
REQ-036 A line fill replaces any previous line at that index; no dirty state exists.

Reset
REQ-037 Rst asserted clears all valid bits, the FSM (to IDLE) and the beat counter; outputs become o_miss=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, o_rdata=0.
REQ-038 Reset during FILL or WRITE abandons the transaction; a mem_ack arriving after reset is ignored.
REQ-039 Data and tag arrays are not reset.

Configuration
REQ-040 When macro DCACHE_STATS_EN is defined, the block adds ports o_hit_cnt (out, 32) and o_miss_cnt (out, 32).
REQ-041 o_hit_cnt increments on each cycle in IDLE with a read hit and i_en=1.
REQ-042 o_miss_cnt increments on each IDLE-to-FILL transition.
REQ-043 Both counters reset to 0 and wrap at 2^32.
REQ-044 Without DCACHE_STATS_EN, the ports and counters are absent and behaviour is otherwise identical.

Verification
REQ-045 Read 0x100 after reset, memory returns 0xA0..0xA3 with ack every cycle: o_miss=1 for 5 cycles, mem_addr 0x100,0x104,0x108,0x10C, then o_rdata=0xA0.
REQ-046 Read 0x108 following the above: o_miss=0 and o_rdata=0xA2 in the same cycle.
REQ-047 Write 0x104 with 0xDEAD, ack after 3 cycles: mem_we=1 and mem_addr=0x104 for 3 cycles, one DONE cycle with o_miss=0, then a read of 0x104 hits with 0xDEAD.
REQ-048 Write 0x2000 (a miss, same index as 0x100 when INDEX_BITS=4), then read 0x100: a hit with the old line intact.
REQ-049 Rst pulse after the 2nd fill beat: mem_req=0 immediately; a re-read of 0x100 misses and refills all 4 beats.
REQ-050 With DCACHE_STATS_EN defined, the REQ-045/046 sequence gives o_hit_cnt=2, o_miss_cnt=1.
